// File: rtl/dram_cmd_scheduler.sv
// dram_cmd_scheduler
// Turns one L2 access at a time into a DRAM command sequence (PRE/ACT/RD/WR)
// under an open-page policy, and slots refresh (PREA/REF) in between
// accesses whenever the refresh counter has asked for one.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_val/req_rdy               request handshake from the request buffer
//   req_we, req_bank/row/col      request attributes (captured on accept)
//   ref_flag                      refresh request pulse (sticky until REF sent)
//   cmd_req/cmd_ack               command handshake to the DRAM array
//   cmd, cmd_bank/row/col         current command and its IDs (zero when idle)
//   done                          one-cycle pulse after a RD/WR is accepted
//   busy                          a sequence is in flight or refresh is owed
module dram_cmd_scheduler #(
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  localparam int BW = $clog2(NUM_OF_BANKS),
  localparam int RW = $clog2(NUM_OF_ROWS),
  localparam int CW = $clog2(NUM_OF_COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_val,
  output logic          req_rdy,
  input  logic          req_we,
  input  logic [BW-1:0] req_bank,
  input  logic [RW-1:0] req_row,
  input  logic [CW-1:0] req_col,
  input  logic          ref_flag,
  output logic          cmd_req,
  input  logic          cmd_ack,
  output logic [2:0]    cmd,
  output logic [BW-1:0] cmd_bank,
  output logic [RW-1:0] cmd_row,
  output logic [CW-1:0] cmd_col,
  output logic          done,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ACT,
    S_RW,
    S_RPREA,
    S_REF
  } state_t;

  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_ACT  = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;
  localparam logic [2:0] CMD_WR   = 3'b011;
  localparam logic [2:0] CMD_PRE  = 3'b100;
  localparam logic [2:0] CMD_PREA = 3'b101;
  localparam logic [2:0] CMD_REF  = 3'b110;

  state_t state, state_next;

  logic                    ref_pending;
  logic [NUM_OF_BANKS-1:0] open_valid;
  logic [RW-1:0]           open_row [NUM_OF_BANKS];

  logic          cap_we;
  logic [BW-1:0] cap_bank;
  logic [RW-1:0] cap_row;
  logic [CW-1:0] cap_col;

  logic req_fire;
  logic table_hit;
  logic any_open;

  assign req_rdy   = (state == S_IDLE) && !ref_pending;
  assign req_fire  = req_val && req_rdy;
  assign table_hit = open_valid[req_bank] && (open_row[req_bank] == req_row);
  assign any_open  = |open_valid;
  assign busy      = (state != S_IDLE) || ref_pending;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Every non-idle state holds cmd_req high, so cmd_ack
  // alone marks the transfer there. Refresh wins in IDLE because req_rdy is
  // already low whenever ref_pending is set.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (ref_pending) begin
          state_next = any_open ? S_RPREA : S_REF;
        end else if (req_val) begin
          if (table_hit) begin
            state_next = S_RW;
          end else if (open_valid[req_bank]) begin
            state_next = S_PRE;
          end else begin
            state_next = S_ACT;
          end
        end
      end
      S_PRE:   if (cmd_ack) state_next = S_ACT;
      S_ACT:   if (cmd_ack) state_next = S_RW;
      S_RW:    if (cmd_ack) state_next = S_IDLE;
      S_RPREA: if (cmd_ack) state_next = S_REF;
      S_REF:   if (cmd_ack) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Command outputs depend only on state and the captured request, so they
  // cannot move while a command waits for its ack.
  always_comb begin
    cmd_req  = 1'b0;
    cmd      = CMD_NOP;
    cmd_bank = '0;
    cmd_row  = '0;
    cmd_col  = '0;
    case (state)
      S_PRE: begin
        cmd_req  = 1'b1;
        cmd      = CMD_PRE;
        cmd_bank = cap_bank;
      end
      S_ACT: begin
        cmd_req  = 1'b1;
        cmd      = CMD_ACT;
        cmd_bank = cap_bank;
        cmd_row  = cap_row;
      end
      S_RW: begin
        cmd_req  = 1'b1;
        cmd      = cap_we ? CMD_WR : CMD_RD;
        cmd_bank = cap_bank;
        cmd_col  = cap_col;
      end
      S_RPREA: begin
        cmd_req = 1'b1;
        cmd     = CMD_PREA;
      end
      S_REF: begin
        cmd_req = 1'b1;
        cmd     = CMD_REF;
      end
      default: ;
    endcase
  end

  // Request capture, bank-valid table, refresh bookkeeping and done pulse.
  // A ref_flag in the same cycle as the REF transfer keeps ref_pending set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_we      <= 1'b0;
      cap_bank    <= '0;
      cap_row     <= '0;
      cap_col     <= '0;
      open_valid  <= '0;
      ref_pending <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (req_fire) begin
        cap_we   <= req_we;
        cap_bank <= req_bank;
        cap_row  <= req_row;
        cap_col  <= req_col;
      end
      if (state == S_PRE && cmd_ack) begin
        open_valid[cap_bank] <= 1'b0;
      end else if (state == S_ACT && cmd_ack) begin
        open_valid[cap_bank] <= 1'b1;
      end else if (state == S_RPREA && cmd_ack) begin
        open_valid <= '0;
      end
      ref_pending <= (ref_pending && !(state == S_REF && cmd_ack)) || ref_flag;
      done        <= (state == S_RW) && cmd_ack;
    end
  end

  // Row IDs need no reset: an entry is only trusted while its valid bit is set.
  always_ff @(posedge clk) begin
    if (state == S_ACT && cmd_ack) begin
      open_row[cap_bank] <= cap_row;
    end
  end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb_dram_cmd_scheduler
// Self-checking bench for dram_cmd_scheduler. A transaction-level model keeps
// its own open-row table and a queue of commands the scheduler still owes;
// every falling edge the DUT outputs are compared against the queue head.
// Directed sequences additionally pin exact cycle-by-cycle literal values.
module tb_dram_cmd_scheduler;

  localparam int BW = 3;
  localparam int RW = 7;
  localparam int CW = 3;
  localparam int NB = 8;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_ACT  = 3'd1;
  localparam logic [2:0] C_RD   = 3'd2;
  localparam logic [2:0] C_WR   = 3'd3;
  localparam logic [2:0] C_PRE  = 3'd4;
  localparam logic [2:0] C_PREA = 3'd5;
  localparam logic [2:0] C_REF  = 3'd6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_val = 1'b0;
  logic          req_rdy;
  logic          req_we = 1'b0;
  logic [BW-1:0] req_bank = '0;
  logic [RW-1:0] req_row = '0;
  logic [CW-1:0] req_col = '0;
  logic          ref_flag = 1'b0;
  logic          cmd_req;
  logic          cmd_ack = 1'b1;
  logic [2:0]    cmd;
  logic [BW-1:0] cmd_bank;
  logic [RW-1:0] cmd_row;
  logic [CW-1:0] cmd_col;
  logic          done;
  logic          busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dram_cmd_scheduler #(
    .NUM_OF_BANKS(8),
    .NUM_OF_ROWS(128),
    .NUM_OF_COLS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_val(req_val),
    .req_rdy(req_rdy),
    .req_we(req_we),
    .req_bank(req_bank),
    .req_row(req_row),
    .req_col(req_col),
    .ref_flag(ref_flag),
    .cmd_req(cmd_req),
    .cmd_ack(cmd_ack),
    .cmd(cmd),
    .cmd_bank(cmd_bank),
    .cmd_row(cmd_row),
    .cmd_col(cmd_col),
    .done(done),
    .busy(busy)
  );

  // ---------------- transaction-level model ----------------
  typedef struct packed {
    logic [2:0]    c;
    logic [BW-1:0] b;
    logic [RW-1:0] r;
    logic [CW-1:0] k;
  } cmd_t;

  cmd_t          owed_q[$];
  bit            m_open [NB];
  logic [RW-1:0] m_row  [NB];
  bit            m_ref  = 1'b0;
  bit            m_done = 1'b0;
  cmd_t          m_head;
  bit            m_idle;
  bit            m_ref_sent;
  bit            m_any;

  function automatic cmd_t mk(input logic [2:0] c, input logic [BW-1:0] b,
                              input logic [RW-1:0] r, input logic [CW-1:0] k);
    cmd_t t;
    t.c = c; t.b = b; t.r = r; t.k = k;
    return t;
  endfunction

  // When nothing is owed the scheduler is idle: it either starts a refresh
  // (if one is owed) or turns an offered request into its command list.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      owed_q.delete();
      for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
      m_ref  = 1'b0;
      m_done = 1'b0;
    end else begin
      m_idle     = (owed_q.size() == 0);
      m_done     = 1'b0;
      m_ref_sent = 1'b0;
      if (!m_idle && cmd_ack) begin
        m_head = owed_q.pop_front();
        if (m_head.c == C_RD || m_head.c == C_WR) m_done = 1'b1;
        if (m_head.c == C_REF) m_ref_sent = 1'b1;
      end
      if (m_idle && m_ref) begin
        m_any = 1'b0;
        for (int i = 0; i < NB; i++) m_any |= m_open[i];
        if (m_any) owed_q.push_back(mk(C_PREA, '0, '0, '0));
        for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
        owed_q.push_back(mk(C_REF, '0, '0, '0));
      end else if (m_idle && req_val) begin
        if (!(m_open[req_bank] && m_row[req_bank] == req_row)) begin
          if (m_open[req_bank]) owed_q.push_back(mk(C_PRE, req_bank, '0, '0));
          owed_q.push_back(mk(C_ACT, req_bank, req_row, '0));
          m_open[req_bank] = 1'b1;
          m_row[req_bank]  = req_row;
        end
        owed_q.push_back(mk(req_we ? C_WR : C_RD, req_bank, '0, req_col));
      end
      m_ref = (m_ref && !m_ref_sent) || ref_flag;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  cmd_t e;
  always @(negedge clk) begin
    e = (owed_q.size() > 0) ? owed_q[0] : mk(C_NOP, '0, '0, '0);
    checkOutput("m_cmd_req", 32'(cmd_req), 32'(owed_q.size() > 0));
    checkOutput("m_cmd", 32'(cmd), 32'(e.c));
    checkOutput("m_cmd_bank", 32'(cmd_bank), 32'(e.b));
    checkOutput("m_cmd_row", 32'(cmd_row), 32'(e.r));
    checkOutput("m_cmd_col", 32'(cmd_col), 32'(e.k));
    checkOutput("m_req_rdy", 32'(req_rdy), 32'((owed_q.size() == 0) && !m_ref));
    checkOutput("m_busy", 32'(busy), 32'((owed_q.size() > 0) || m_ref));
    checkOutput("m_done", 32'(done), 32'(m_done));
  end

  // ---------------- directed stimulus ----------------
  task automatic applyStimulus(input bit v, input bit we, input logic [BW-1:0] b,
                               input logic [RW-1:0] r, input logic [CW-1:0] c,
                               input bit ack, input bit rf);
    req_val  = v;
    req_we   = we;
    req_bank = b;
    req_row  = r;
    req_col  = c;
    cmd_ack  = ack;
    ref_flag = rf;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("rst_cmd_req", 32'(cmd_req), 32'd0);
    checkOutput("rst_cmd", 32'(cmd), 32'(C_NOP));
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    // Closed bank read: ACT, RD, done.
    applyStimulus(1, 0, 3'd2, 7'd5, 3'd3, 1, 0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("t1_act", 32'(cmd), 32'(C_ACT));
    checkOutput("t1_act_bank", 32'(cmd_bank), 32'd2);
    checkOutput("t1_act_row", 32'(cmd_row), 32'd5);
    checkOutput("t1_rdy_low", 32'(req_rdy), 32'd0);
    nextCycle();
    checkOutput("t1_rd", 32'(cmd), 32'(C_RD));
    checkOutput("t1_rd_col", 32'(cmd_col), 32'd3);
    checkOutput("t1_rd_row0", 32'(cmd_row), 32'd0);
    nextCycle();
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_rdy", 32'(req_rdy), 32'd1);

    // Page hit write, issued in the done cycle.
    applyStimulus(1, 1, 3'd2, 7'd5, 3'd7, 1, 0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("t2_wr", 32'(cmd), 32'(C_WR));
    checkOutput("t2_wr_col", 32'(cmd_col), 32'd7);
    nextCycle();
    checkOutput("t2_done", 32'(done), 32'd1);

    // Row conflict: PRE, ACT, RD.
    applyStimulus(1, 0, 3'd2, 7'd9, 3'd0, 1, 0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("t3_pre", 32'(cmd), 32'(C_PRE));
    checkOutput("t3_pre_bank", 32'(cmd_bank), 32'd2);
    nextCycle();
    checkOutput("t3_act_row", 32'(cmd_row), 32'd9);
    nextCycle();
    checkOutput("t3_rd", 32'(cmd), 32'(C_RD));
    nextCycle();
    checkOutput("t3_done", 32'(done), 32'd1);

    // ACT stalled three cycles by cmd_ack low.
    applyStimulus(1, 0, 3'd5, 7'd1, 3'd2, 0, 0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t4_act1", 32'(cmd), 32'(C_ACT));
    checkOutput("t4_act1_bank", 32'(cmd_bank), 32'd5);
    nextCycle();
    checkOutput("t4_act2_row", 32'(cmd_row), 32'd1);
    nextCycle();
    checkOutput("t4_act3", 32'(cmd), 32'(C_ACT));
    checkOutput("t4_nodone", 32'(done), 32'd0);
    nextCycle(); cmd_ack = 1'b1;
    checkOutput("t4_act4", 32'(cmd), 32'(C_ACT));
    checkOutput("t4_act4_req", 32'(cmd_req), 32'd1);
    nextCycle();
    checkOutput("t4_rd_col", 32'(cmd_col), 32'd2);
    nextCycle();
    checkOutput("t4_done", 32'(done), 32'd1);

    // Refresh while banks are open and a request waits.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    nextCycle(); applyStimulus(1, 0, 3'd2, 7'd9, 3'd4, 1, 0);
    checkOutput("t5_rdy_low", 32'(req_rdy), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd1);
    checkOutput("t5_noreq", 32'(cmd_req), 32'd0);
    nextCycle();
    checkOutput("t5_prea", 32'(cmd), 32'(C_PREA));
    checkOutput("t5_prea_bank", 32'(cmd_bank), 32'd0);
    nextCycle();
    checkOutput("t5_ref", 32'(cmd), 32'(C_REF));
    nextCycle();
    checkOutput("t5_rdy", 32'(req_rdy), 32'd1);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("t5_act", 32'(cmd), 32'(C_ACT));
    checkOutput("t5_act_row", 32'(cmd_row), 32'd9);
    nextCycle();
    checkOutput("t5_rd_col", 32'(cmd_col), 32'd4);
    nextCycle();
    checkOutput("t5_done", 32'(done), 32'd1);

    // Reset during a stalled PRE.
    applyStimulus(1, 0, 3'd2, 7'd3, 3'd1, 0, 0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("t6_pre", 32'(cmd), 32'(C_PRE));
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_req", 32'(cmd_req), 32'd0);
    checkOutput("t6_rst_cmd", 32'(cmd), 32'(C_NOP));
    nextCycle(); rst = 1'b0;
    applyStimulus(1, 0, 3'd2, 7'd3, 3'd1, 1, 0);
    nextCycle(); applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkOutput("t6_act", 32'(cmd), 32'(C_ACT));
    checkOutput("t6_act_row", 32'(cmd_row), 32'd3);
    nextCycle();
    nextCycle();
    checkOutput("t6_done", 32'(done), 32'd1);

    // ref_flag during the REF transfer leaves another refresh owed.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    nextCycle(); ref_flag = 1'b0;
    nextCycle();
    checkOutput("t7_prea", 32'(cmd), 32'(C_PREA));
    nextCycle(); ref_flag = 1'b1;
    checkOutput("t7_ref", 32'(cmd), 32'(C_REF));
    nextCycle(); ref_flag = 1'b0;
    checkOutput("t7_rdy_low", 32'(req_rdy), 32'd0);
    checkOutput("t7_idle_req", 32'(cmd_req), 32'd0);
    nextCycle();
    checkOutput("t7_ref2", 32'(cmd), 32'(C_REF));
    nextCycle();
    checkOutput("t7_rdy", 32'(req_rdy), 32'd1);
    checkOutput("t7_busy", 32'(busy), 32'd0);

    // Mixed traffic over a few banks/rows, checked by the model only.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    BW'($urandom_range(0, 3)), RW'($urandom_range(0, 2)),
                    CW'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 19) == 0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    repeat (20) nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dram_cmd_scheduler.md
Name: dram_cmd_scheduler

Overview:
- Sequences each L2 access into DRAM commands (PRE/ACT/RD/WR) under an open-page policy, and interleaves refresh requests from the refresh counter.
- Keeps a per-bank open-row table and sits between the address translator/request buffer and the command handshake (cmd_req/cmd_ack) to the DRAM array.
- Bank/row/col outputs are binary IDs that drive the downstream bank, row and column decoders.

Parameters:
NUM_OF_BANKS, 8, number of banks; bank ID width BW = $clog2(NUM_OF_BANKS)
NUM_OF_ROWS, 128, rows per bank; row ID width RW = $clog2(NUM_OF_ROWS)
NUM_OF_COLS, 8, columns per row; col ID width CW = $clog2(NUM_OF_COLS)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
req_val  in  1  L2 request valid
req_rdy  out  1  scheduler can accept a request
req_we  in  1  1 = write, 0 = read
req_bank  in  BW  target bank
req_row  in  RW  target row
req_col  in  CW  target column
ref_flag  in  1  refresh request pulse from refresh counter
cmd_req  out  1  command valid to DRAM
cmd_ack  in  1  DRAM accepts current command
cmd  out  3  000 NOP, 001 ACT, 010 RD, 011 WR, 100 PRE, 101 PREA, 110 REF
cmd_bank  out  BW  command bank (0 for PREA/REF/NOP)
cmd_row  out  RW  command row (valid for ACT, else 0)
cmd_col  out  CW  command column (valid for RD/WR, else 0)
done  out  1  one-cycle pulse: request's RD/WR accepted
busy  out  1  state != IDLE or ref_pending

Behaviour:
- Reset (async): state IDLE, open-row table all invalid, ref_pending 0, cmd_req 0, cmd NOP, cmd_bank/row/col 0, done 0, busy 0. req_rdy 1 after reset unless ref_flag is sampled high.
- Handshake: command transfers in the cycle where cmd_req & cmd_ack both high. cmd/cmd_bank/cmd_row/cmd_col stay stable while cmd_req high and no ack. The next command may assert cmd_req in the following cycle (back-to-back). Ack while cmd_req low is ignored.
- When cmd_req is low, cmd = NOP and ID outputs = 0.
- req_rdy = (state == IDLE) & !ref_pending. The request is captured on req_val & req_rdy; inputs are ignored otherwise.
- ref_pending:
  - set on ref_flag high (sticky, multiple pulses merge);
  - cleared on REF transfer;
  - ref_flag in the same cycle as the REF transfer leaves it set.
- States: IDLE, PRE, ACT, RW, RPREA, REF. Every non-IDLE state drives cmd_req = 1 with its command.
- IDLE:
  - If ref_pending: go to RPREA if any bank is open, else REF. Refresh has priority over a simultaneous req_val, because req_rdy is 0.
  - Else, on request accept:
    - table hit (bank valid and row match) -> RW;
    - bank open on another row -> PRE;
    - bank closed -> ACT.
- PRE: cmd PRE on captured bank. On ack, invalidate that bank and go to ACT.
- ACT: cmd ACT with bank/row. On ack, mark bank valid with row and go to RW.
- RW: cmd RD or WR per req_we, with bank/col. On ack, go to IDLE and register done = 1 for the next cycle. The row stays open.
- RPREA: cmd PREA. On ack, invalidate all banks and go to REF.
- REF: cmd REF. On ack, clear ref_pending (unless re-set) and go to IDLE.
- Latency, with ack in the same cycle it is requested:
  - request accepted at cycle N; first command at N+1;
  - hit: done at N+2; closed bank: N+3; row conflict: N+4.
- done and req_rdy may be high in the same cycle, so a new request can be accepted then.
- A ref_flag arriving mid-transaction does not abort it; refresh starts at the next IDLE.
- Reset mid-operation aborts immediately. No partial command completes, and the table is invalidated.
- IDs are stored unmodified. No arithmetic, no wrap-around.

Test Plan:
- Reset, then read bank 2 row 5 col 3 with cmd_ack tied high -> ACT(b2,r5) at N+1, RD(b2,c3) at N+2, done at N+3.
- Then write bank 2 row 5 col 7 -> single WR(b2,c7) at N+1, done at N+2 (page hit, no ACT).
- Then read bank 2 row 9 col 0 -> PRE(b2), ACT(b2,r9), RD(b2,c0), done at N+4.
- Hold cmd_ack low 3 cycles during ACT -> cmd_req/cmd/IDs stable for all 4 cycles; advance only on ack; done delayed by 3.
- ref_flag pulse while bank 2 open and a request is waiting -> req_rdy 0, PREA then REF, then the request is accepted and issues ACT (table cleared).
- Assert rst during PRE with cmd_ack low -> cmd_req 0, cmd NOP immediately; the next access to the same bank issues ACT without PRE.
